// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the five-stage Y86-64 core.
// Produces per-stage stall/bubble controls (load/use, ret, mispredict,
// exception drain) and sequences the run state INIT -> RUN -> HALT.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned ICODE_W     = 4,
  parameter int unsigned REG_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ICODE_W-1:0] D_icode,
  input  logic [REG_W-1:0]   d_srcA,
  input  logic [REG_W-1:0]   d_srcB,
  input  logic [ICODE_W-1:0] E_icode,
  input  logic [REG_W-1:0]   E_dstM,
  input  logic               e_Cnd,
  input  logic [ICODE_W-1:0] M_icode,
  input  logic [2:0]         m_stat,
  input  logic [2:0]         W_stat,
  output logic               F_stall,
  output logic               D_stall,
  output logic               D_bubble,
  output logic               E_bubble,
  output logic               M_bubble,
  output logic               W_stall,
  output logic [1:0]         cpu_state,
  output logic               halted
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]        cyc_cnt,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        squash_cnt
`endif
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [ICODE_W-1:0] I_MRMOVQ = ICODE_W'(5);
  localparam logic [ICODE_W-1:0] I_JXX    = ICODE_W'(7);
  localparam logic [ICODE_W-1:0] I_RET    = ICODE_W'(9);
  localparam logic [ICODE_W-1:0] I_POPQ   = ICODE_W'(11);
  localparam logic [REG_W-1:0]   R_NONE   = '1;
  localparam logic [3:0]         INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic loaduse, retpend, mispred, m_exc, w_exc;

  function automatic logic is_exc(input logic [2:0] s);
    return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
  endfunction

  // Raw hazard conditions decoded from the pipeline register contents.
  always_comb begin
    loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
              (E_dstM != R_NONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    retpend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mispred = (E_icode == I_JXX) && !e_Cnd;
    m_exc   = is_exc(m_stat);
    w_exc   = is_exc(W_stat);
  end

  // Next-state and init-counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == INIT_LAST) state_d = S_RUN;
      end
      S_RUN:   if (w_exc) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall/bubble controls: combinational from state and inputs.
  // Asserted reset overrides the state so bubbles flow immediately.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b1;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_INIT: F_stall = 1'b1;
        S_RUN: begin
          F_stall  = loaduse || retpend;
          D_stall  = loaduse;
          D_bubble = mispred || (retpend && !loaduse);
          E_bubble = mispred || loaduse;
          M_bubble = m_exc || w_exc;
          W_stall  = w_exc;
        end
        S_HALT: begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          D_bubble = 1'b0;
          E_bubble = 1'b0;
          M_bubble = 1'b1;
          W_stall  = 1'b1;
        end
        default: F_stall = 1'b0;
      endcase
    end
  end

  assign cpu_state = state_q;
  assign halted    = (state_q == S_HALT);

`ifdef PIPE_CTRL_PERF_EN
  // Performance counters: count only while running, frozen in HALT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt    <= '0;
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else if (state_q == S_RUN) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (F_stall) stall_cnt  <= stall_cnt + 32'd1;
      if (mispred) squash_cnt <= squash_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 core.
- Generates per-stage stall and bubble controls for the F/D/E/M/W pipeline registers: load/use interlock, ret stall, mispredicted-jump squash, exception drain.
- Sequences processor run state from reset through normal execution to a terminal halt.
- Works alongside fetch PC selection: mispredict and ret recovery take effect there, while this block squashes or holds the wrong-path stages.

Parameters:
- INIT_CYCLES, 2, cycles spent flushing all pipeline registers after reset release (1..15).
- ICODE_W, 4, instruction-code width.
- REG_W, 4, register-ID width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- D_icode  input  ICODE_W  icode in D register.
- d_srcA  input  REG_W  decode source A ID (4'hF = none).
- d_srcB  input  REG_W  decode source B ID (4'hF = none).
- E_icode  input  ICODE_W  icode in E register.
- E_dstM  input  REG_W  memory destination in E register (4'hF = none).
- e_Cnd  input  1  execute-stage condition result.
- M_icode  input  ICODE_W  icode in M register.
- m_stat  input  3  memory-stage status.
- W_stat  input  3  writeback status.
- F_stall  output  1  hold F register (predPC).
- D_stall  output  1  hold D register.
- D_bubble  output  1  load nop into D.
- E_bubble  output  1  load nop into E.
- M_bubble  output  1  load nop into M.
- W_stall  output  1  hold W register.
- cpu_state  output  2  0=INIT, 1=RUN, 2=HALT.
- halted  output  1  high in HALT.

Behaviour:
- Encodings: JXX=7, RET=9, MRMOVQ=5, POPQ=B. Stat AOK=1, HLT=2, ADR=3, INS=4; any other stat value is treated as AOK.
- Reset (rst_n=0 at a clk edge): state=INIT, init counter=0.
  - During reset the outputs are: D_bubble=E_bubble=M_bubble=1; F_stall=D_stall=W_stall=0; cpu_state=0; halted=0.
- INIT:
  - Drive D/E/M_bubble=1, F_stall=1, D_stall=0, W_stall=0. All hazard inputs are ignored.
  - Counter increments each cycle. After INIT_CYCLES cycles, go to RUN.
- RUN: control outputs are combinational from the inputs.
  - loaduse = (E_icode in {MRMOVQ,POPQ}) and E_dstM != 4'hF and (E_dstM==d_srcA or E_dstM==d_srcB).
  - retpend = RET in {D_icode, E_icode, M_icode}.
  - mispred = (E_icode==JXX) and !e_Cnd.
  - F_stall = loaduse or retpend.
  - D_stall = loaduse.
  - D_bubble = mispred or (retpend and !loaduse).
  - E_bubble = mispred or loaduse.
  - M_bubble = m_stat in {HLT,ADR,INS} or W_stat in {HLT,ADR,INS}.
  - W_stall = W_stat in {HLT,ADR,INS}.
  - Priority: D_stall and D_bubble are never both 1; stall wins (loaduse blocks the ret bubble). E_bubble on mispred plus loaduse is a single bubble.
  - Transition: W_stat in {HLT,ADR,INS} at the clock edge -> HALT. The same cycle already drives W_stall=1.
- HALT (terminal until reset):
  - F_stall=1, D_stall=1, W_stall=1, M_bubble=1, D_bubble=0, E_bubble=0.
  - halted=1, cpu_state=2. All inputs are ignored.
- Reset mid-operation: any state -> INIT on the next edge with rst_n=0. The counter restarts at 0.
- cpu_state and halted are registered. Stall/bubble outputs are combinational from state plus inputs, with no added latency.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Enabled: adds output ports cyc_cnt[31:0], stall_cnt[31:0], squash_cnt[31:0].
  - All three clear on reset and count only in RUN.
  - cyc_cnt increments every RUN cycle.
  - stall_cnt increments when F_stall=1.
  - squash_cnt increments when mispred=1.
  - All three wrap at 2^32 and freeze in HALT.
- Disabled: ports and counters are absent. Control behaviour is identical either way.

Test Plan:
- Reset release with INIT_CYCLES=2:
  - Cycles 0-1 after release: D/E/M_bubble=1, F_stall=1, cpu_state=0.
  - Cycle 2: cpu_state=1; with neutral inputs, all controls are 0.
- Load/use in RUN, E_icode=5, E_dstM=3, d_srcA=3:
  - F_stall=1, D_stall=1, E_bubble=1, D_bubble=0.
  - Same with E_dstM=F, d_srcA=F: all controls 0.
- Ret: D_icode=9 for one cycle, then E_icode=9, then M_icode=9:
  - Each of the three cycles: F_stall=1, D_bubble=1.
  - Next cycle with no RET anywhere: all 0.
- Mispredict, E_icode=7, e_Cnd=0:
  - D_bubble=1, E_bubble=1, F_stall=0.
  - Combined with D_icode=9: still a single D_bubble, and F_stall=1.
- Exception, m_stat=3 (ADR), W_stat=1:
  - M_bubble=1, W_stall=0, state stays RUN.
  - Next cycle W_stat=3: W_stall=1. Following edge: halted=1, cpu_state=2.
  - Outputs then hold regardless of inputs until rst_n=0, which returns to INIT.
- With PIPE_CTRL_PERF_EN:
  - 10 RUN cycles including 3 load-use cycles and 1 mispredict: cyc_cnt=10, stall_cnt=3, squash_cnt=1.
  - Counts stay frozen after HALT.
